// File: rtl/spi_slave_fifo.sv
// SPI slave with TX/RX first-word-fall-through FIFOs.
// All SPI pins are oversampled on clk; mode and bit order are captured
// at the start of every chip-select frame and held until it ends.

// Synchronous FWFT FIFO. A push into a full FIFO is refused even when a pop
// happens in the same cycle, so fullness is judged on the pre-pop level.
module spi_slave_fifo_buf #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [width-1:0]         wr_data,
    input  logic                     pop,
    output logic [width-1:0]         rd_data,
    output logic [$clog2(depth):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int ptr_w = $clog2(depth);
    localparam int lvl_w = ptr_w + 1;

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [lvl_w-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == lvl_w'(depth));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO state registers; reset empties the FIFO and clears its storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

module spi_slave_fifo #(
    parameter int data_width = 8,
    parameter int fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          lsb_first,
    input  logic                          spi_clk,
    input  logic                          chip_select,
    input  logic                          MOSI,
    output logic                          MISO,
    input  logic [data_width-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [data_width-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(fifo_depth):0]   tx_level,
    output logic [$clog2(fifo_depth):0]   rx_level,
    output logic                          busy,
    output logic                          tx_underrun,
    output logic                          rx_overrun,
    output logic                          frame_error
);
    localparam int cnt_w = $clog2(data_width);
    localparam logic [cnt_w-1:0] last_bit = cnt_w'(data_width - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // Pin pipelines, bit 2 = spi_clk, bit 1 = chip_select, bit 0 = MOSI.
    // The idle level of chip_select is high, so its stages reset to 1.
    localparam logic [2:0] pins_idle = 3'b010;

    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic [2:0] prev_q, prev_d;

    state_t                 state_q, state_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   cpol_m_q, cpol_m_d;
    logic                   cpha_m_q, cpha_m_d;
    logic                   lsb_m_q, lsb_m_d;
    logic [cnt_w-1:0]       cnt_q, cnt_d;
    logic [data_width-1:0]  shift_q, shift_d;
    logic [data_width-1:0]  rx_shift_q, rx_shift_d;
    logic [data_width-1:0]  rx_word_q, rx_word_d;
    logic                   word_done_q, word_done_d;
    logic                   load_pend_q, load_pend_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   rx_overrun_q, rx_overrun_d;
    logic                   frame_error_q, frame_error_d;

    logic                   sclk_rise, sclk_fall;
    logic                   cs_fall, cs_rise;
    logic                   mosi_bit;
    logic                   sample_ev, shift_ev;
    logic                   load_req;
    logic                   tx_pop;
    logic [data_width-1:0]  tx_head;
    logic [data_width-1:0]  rx_next;
    logic                   tx_full, tx_empty;
    logic                   rx_full, rx_empty;

    assign sclk_rise = sync_q[2] & ~prev_q[2];
    assign sclk_fall = ~sync_q[2] & prev_q[2];
    assign cs_fall   = ~sync_q[1] & prev_q[1];
    assign cs_rise   = sync_q[1] & ~prev_q[1];
    assign mosi_bit  = prev_q[0];

    // With cpol^cpha clear the sample edge is the rising one, otherwise falling.
    assign sample_ev = (cpol_m_q ^ cpha_m_q) ? fall_q : rise_q;
    assign shift_ev  = (cpol_m_q ^ cpha_m_q) ? rise_q : fall_q;

    assign rx_next = lsb_m_q ? {mosi_bit, rx_shift_q[data_width-1:1]}
                             : {rx_shift_q[data_width-2:0], mosi_bit};

    assign busy        = (state_q == ST_ACTIVE);
    assign MISO        = busy & (lsb_m_q ? shift_q[0] : shift_q[data_width-1]);
    assign tx_ready    = ~tx_full;
    assign rx_valid    = ~rx_empty;
    assign tx_underrun = tx_underrun_q;
    assign rx_overrun  = rx_overrun_q;
    assign frame_error = frame_error_q;

    spi_slave_fifo_buf #(.width(data_width), .depth(fifo_depth)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_valid & tx_ready),
        .wr_data (tx_data),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .level   (tx_level),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    spi_slave_fifo_buf #(.width(data_width), .depth(fifo_depth)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (word_done_q),
        .wr_data (rx_word_q),
        .pop     (rx_valid & rx_ready),
        .rd_data (rx_data),
        .level   (rx_level),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    // Frame control, edge decoding, shift registers and the TX load decision.
    always_comb begin
        meta_d        = {spi_clk, chip_select, MOSI};
        sync_d        = meta_q;
        prev_d        = sync_q;
        state_d       = state_q;
        rise_d        = busy & sclk_rise;
        fall_d        = busy & sclk_fall;
        cpol_m_d      = cpol_m_q;
        cpha_m_d      = cpha_m_q;
        lsb_m_d       = lsb_m_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        rx_shift_d    = rx_shift_q;
        rx_word_d     = rx_word_q;
        word_done_d   = 1'b0;
        load_pend_d   = load_pend_q;
        tx_underrun_d = 1'b0;
        rx_overrun_d  = word_done_q & rx_full;
        frame_error_d = 1'b0;
        load_req      = 1'b0;
        tx_pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    cpol_m_d    = cpol;
                    cpha_m_d    = cpha;
                    lsb_m_d     = lsb_first;
                    cnt_d       = '0;
                    load_pend_d = 1'b0;
                    load_req    = ~cpha;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    shift_d       = '0;
                    rx_shift_d    = '0;
                    load_pend_d   = 1'b0;
                    rise_d        = 1'b0;
                    fall_d        = 1'b0;
                    frame_error_d = (cnt_q != '0);
                end else begin
                    if (sample_ev) begin
                        rx_shift_d = rx_next;
                        if (cnt_q == last_bit) begin
                            cnt_d       = '0;
                            rx_word_d   = rx_next;
                            word_done_d = 1'b1;
                            load_pend_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (shift_ev) begin
                        if (cpha_m_q ? (cnt_q == '0) : load_pend_q) begin
                            load_req    = 1'b1;
                            load_pend_d = 1'b0;
                        end else if (lsb_m_q) begin
                            shift_d = {1'b0, shift_q[data_width-1:1]};
                        end else begin
                            shift_d = {shift_q[data_width-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_req) begin
            tx_pop        = ~tx_empty;
            shift_d       = tx_empty ? '0 : tx_head;
            tx_underrun_d = tx_empty;
        end
    end

    // Single register bank for the whole slave; reset returns everything to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q        <= pins_idle;
            sync_q        <= pins_idle;
            prev_q        <= pins_idle;
            state_q       <= ST_IDLE;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            cpol_m_q      <= 1'b0;
            cpha_m_q      <= 1'b0;
            lsb_m_q       <= 1'b0;
            cnt_q         <= '0;
            shift_q       <= '0;
            rx_shift_q    <= '0;
            rx_word_q     <= '0;
            word_done_q   <= 1'b0;
            load_pend_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            state_q       <= state_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            cpol_m_q      <= cpol_m_d;
            cpha_m_q      <= cpha_m_d;
            lsb_m_q       <= lsb_m_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_word_q     <= rx_word_d;
            word_done_q   <= word_done_d;
            load_pend_q   <= load_pend_d;
            tx_underrun_q <= tx_underrun_d;
            rx_overrun_q  <= rx_overrun_d;
            frame_error_q <= frame_error_d;
        end
    end
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Testbench for spi_slave_fifo: a behavioural SPI master plus a scoreboard
// holding the words the slave should receive and the words it should shift out.
module tb_spi_slave_fifo;
    localparam int W    = 8;
    localparam int D    = 4;
    localparam int HALF = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic          spi_clk = 1'b0, chip_select = 1'b1, MOSI = 1'b0;
    logic          MISO;
    logic [W-1:0]  tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [2:0]    tx_level, rx_level;
    logic          busy, tx_underrun, rx_overrun, frame_error;

    spi_slave_fifo #(.data_width(W), .fifo_depth(D)) dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .spi_clk(spi_clk), .chip_select(chip_select), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level), .busy(busy),
        .tx_underrun(tx_underrun), .rx_overrun(rx_overrun), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Scoreboard: words queued for transmission and words expected at rx_data.
    logic [W-1:0] tx_exp_q[$];
    logic [W-1:0] rx_exp_q[$];
    logic         m_cpol, m_cpha, m_lsb;
    logic [W-1:0] m_loaded;
    int           exp_underrun = 0;
    int           exp_overrun  = 0;

    // Running pulse counts observed on the error outputs.
    int n_underrun = 0, n_overrun = 0, n_frame_err = 0;
    always @(negedge clk) begin
        if (tx_underrun) n_underrun++;
        if (rx_overrun)  n_overrun++;
        if (frame_error) n_frame_err++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [W-1:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        if (tx_exp_q.size() < D) tx_exp_q.push_back(w);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Slave shift-register load as the master expects it to happen.
    task automatic model_load();
        if (tx_exp_q.size() > 0) begin
            m_loaded = tx_exp_q.pop_front();
        end else begin
            m_loaded = '0;
            exp_underrun++;
        end
    endtask

    task automatic frame_begin(input logic pol, input logic pha, input logic lsb);
        m_cpol = pol; m_cpha = pha; m_lsb = lsb;
        cpol = pol; cpha = pha; lsb_first = lsb;
        spi_clk = pol;
        wait_clks(HALF);
        chip_select = 1'b0;
        if (!pha) model_load();
        wait_clks(HALF);
    endtask

    task automatic frame_end();
        wait_clks(HALF);
        chip_select = 1'b1;
        wait_clks(2 * HALF);
    endtask

    task automatic spi_bit(input logic mosi_b, output logic miso_b);
        if (!m_cpha) begin
            MOSI = mosi_b;
            wait_clks(HALF);
            miso_b  = MISO;
            spi_clk = ~spi_clk;
            wait_clks(HALF);
            spi_clk = ~spi_clk;
        end else begin
            spi_clk = ~spi_clk;
            MOSI    = mosi_b;
            wait_clks(HALF);
            miso_b  = MISO;
            spi_clk = ~spi_clk;
            wait_clks(HALF);
        end
    endtask

    // One full word; also predicts the MISO word and the RX FIFO outcome.
    task automatic spi_word(input logic [W-1:0] mosi_w, output logic [W-1:0] miso_w,
                            output logic [W-1:0] miso_exp);
        logic b;
        int   idx;
        miso_w = '0;
        if (m_cpha) model_load();
        miso_exp = m_loaded;
        for (int i = 0; i < W; i++) begin
            idx = m_lsb ? i : W - 1 - i;
            spi_bit(mosi_w[idx], b);
            miso_w[idx] = b;
        end
        if (!m_cpha) model_load();
        if (rx_exp_q.size() < D) rx_exp_q.push_back(mosi_w);
        else exp_overrun++;
    endtask

    task automatic pop_rx(output logic [W-1:0] d, output logic ok);
        ok = 1'b0;
        d  = '0;
        for (int i = 0; i < 60 && !rx_valid; i++) @(negedge clk);
        if (rx_valid) begin
            ok = 1'b1;
            d  = rx_data;
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        wait_clks(3);
        rst = 1'b0;
        wait_clks(4);
        checks++; if (MISO !== 1'b0) $display("[TB] FAIL reset_miso got %b want 0", MISO); else passed++;
        checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL reset_tx_ready got %b want 1", tx_ready); else passed++;
        checks++; if (rx_valid !== 1'b0) $display("[TB] FAIL reset_rx_valid got %b want 0", rx_valid); else passed++;
        checks++; if (tx_level !== 3'd0) $display("[TB] FAIL reset_tx_level got %0d want 0", tx_level); else passed++;
        checks++; if (rx_level !== 3'd0) $display("[TB] FAIL reset_rx_level got %0d want 0", rx_level); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if ({tx_underrun, rx_overrun, frame_error} !== 3'b000)
            $display("[TB] FAIL reset_pulses got %b want 000", {tx_underrun, rx_overrun, frame_error}); else passed++;
        checks++; if (rx_data !== '0) $display("[TB] FAIL reset_rx_data got %h want 00", rx_data); else passed++;
    endtask

    task automatic test_mode0_msb();
        logic [W-1:0] got, exp, d;
        logic ok;
        int fe0;
        fe0 = n_frame_err;
        push_tx(8'hA5);
        checks++; if (tx_level !== 3'd1) $display("[TB] FAIL m0_tx_level_pre got %0d want 1", tx_level); else passed++;
        frame_begin(1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL m0_busy got %b want 1", busy); else passed++;
        spi_word(8'h3C, got, exp);
        checks++; if (got !== exp) $display("[TB] FAIL m0_miso got %h want %h", got, exp); else passed++;
        frame_end();
        checks++; if (tx_level !== 3'(tx_exp_q.size())) $display("[TB] FAIL m0_tx_level got %0d want %0d", tx_level, tx_exp_q.size()); else passed++;
        checks++; if (n_frame_err != fe0) $display("[TB] FAIL m0_frame_error got %0d want %0d", n_frame_err - fe0, 0); else passed++;
        while (rx_exp_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            pop_rx(d, ok);
            checks++; if (!ok || d !== exp) $display("[TB] FAIL m0_rx_data got %h valid %b want %h", d, ok, exp); else passed++;
        end
    endtask

    task automatic test_mode3_lsb();
        logic [W-1:0] got, exp, d;
        logic ok;
        push_tx(8'h81);
        frame_begin(1'b1, 1'b1, 1'b1);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        spi_word(8'hF0, got, exp);
        checks++; if (got !== exp) $display("[TB] FAIL m3_miso got %h want %h", got, exp); else passed++;
        frame_end();
        while (rx_exp_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            pop_rx(d, ok);
            checks++; if (!ok || d !== exp) $display("[TB] FAIL m3_rx_data got %h valid %b want %h", d, ok, exp); else passed++;
        end
    endtask

    task automatic test_burst();
        logic [W-1:0] got, exp, d;
        logic [W-1:0] mosi_words [3];
        logic ok;
        int u0, o0, f0, eu0, eo0;
        mosi_words[0] = 8'hAA; mosi_words[1] = 8'hBB; mosi_words[2] = 8'hCC;
        u0 = n_underrun; o0 = n_overrun; f0 = n_frame_err;
        eu0 = exp_underrun; eo0 = exp_overrun;
        push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
        checks++; if (tx_level !== 3'd3) $display("[TB] FAIL burst_tx_level got %0d want 3", tx_level); else passed++;
        frame_begin(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            spi_word(mosi_words[k], got, exp);
            checks++; if (got !== exp) $display("[TB] FAIL burst_miso%0d got %h want %h", k, got, exp); else passed++;
        end
        frame_end();
        checks++; if (n_underrun - u0 != exp_underrun - eu0) $display("[TB] FAIL burst_underrun got %0d want %0d", n_underrun - u0, exp_underrun - eu0); else passed++;
        checks++; if (n_overrun - o0 != exp_overrun - eo0) $display("[TB] FAIL burst_overrun got %0d want %0d", n_overrun - o0, exp_overrun - eo0); else passed++;
        checks++; if (n_frame_err != f0) $display("[TB] FAIL burst_frame_error got %0d want 0", n_frame_err - f0); else passed++;
        while (rx_exp_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            pop_rx(d, ok);
            checks++; if (!ok || d !== exp) $display("[TB] FAIL burst_rx_data got %h valid %b want %h", d, ok, exp); else passed++;
        end
    endtask

    // With cpha=0 the final trailing edge of a frame also loads, so an empty
    // TX FIFO underruns once more than the number of words in the frame.
    task automatic test_underrun();
        logic [W-1:0] got, exp, d;
        logic ok;
        int u0, eu0;
        u0 = n_underrun; eu0 = exp_underrun;
        frame_begin(1'b0, 1'b0, 1'b0);
        spi_word(8'h12, got, exp);
        checks++; if (got !== exp) $display("[TB] FAIL ur_miso0 got %h want %h", got, exp); else passed++;
        spi_word(8'h34, got, exp);
        checks++; if (got !== exp) $display("[TB] FAIL ur_miso1 got %h want %h", got, exp); else passed++;
        frame_end();
        checks++; if (n_underrun - u0 != exp_underrun - eu0) $display("[TB] FAIL ur_pulses got %0d want %0d", n_underrun - u0, exp_underrun - eu0); else passed++;
        while (rx_exp_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            pop_rx(d, ok);
            checks++; if (!ok || d !== exp) $display("[TB] FAIL ur_rx_data got %h valid %b want %h", d, ok, exp); else passed++;
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] got, exp, d;
        logic ok;
        int o0, eo0;
        o0 = n_overrun; eo0 = exp_overrun;
        frame_begin(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) spi_word(W'(k), got, exp);
        frame_end();
        checks++; if (rx_level !== 3'(rx_exp_q.size())) $display("[TB] FAIL or_rx_level got %0d want %0d", rx_level, rx_exp_q.size()); else passed++;
        checks++; if (n_overrun - o0 != exp_overrun - eo0) $display("[TB] FAIL or_pulses got %0d want %0d", n_overrun - o0, exp_overrun - eo0); else passed++;
        while (rx_exp_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            pop_rx(d, ok);
            checks++; if (!ok || d !== exp) $display("[TB] FAIL or_rx_data got %h valid %b want %h", d, ok, exp); else passed++;
        end
        wait_clks(2);
        checks++; if (rx_valid !== 1'b0) $display("[TB] FAIL or_drained got %b want 0", rx_valid); else passed++;
    endtask

    task automatic test_abort();
        logic [W-1:0] got, exp, d;
        logic ok, b;
        logic [4:0] bits;
        int f0;
        bits = 5'b10110;
        f0 = n_frame_err;
        frame_begin(1'b0, 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) spi_bit(bits[i], b);
        frame_end();
        checks++; if (n_frame_err - f0 != 1) $display("[TB] FAIL abort_frame_error got %0d want 1", n_frame_err - f0); else passed++;
        checks++; if (rx_level !== 3'd0) $display("[TB] FAIL abort_rx_level got %0d want 0", rx_level); else passed++;
        frame_begin(1'b0, 1'b0, 1'b0);
        spi_word(8'h5A, got, exp);
        frame_end();
        while (rx_exp_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            pop_rx(d, ok);
            checks++; if (!ok || d !== exp) $display("[TB] FAIL abort_next_rx got %h valid %b want %h", d, ok, exp); else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] got, exp, d;
        logic ok, b;
        push_tx(8'h77); push_tx(8'h66);
        checks++; if (tx_level !== 3'd2) $display("[TB] FAIL rmf_tx_level_pre got %0d want 2", tx_level); else passed++;
        frame_begin(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
        rst = 1'b1;
        chip_select = 1'b1; spi_clk = 1'b0; MOSI = 1'b0;
        tx_exp_q.delete();
        rx_exp_q.delete();
        wait_clks(3);
        rst = 1'b0;
        wait_clks(4);
        checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL rmf_tx_ready got %b want 1", tx_ready); else passed++;
        checks++; if (tx_level !== 3'd0) $display("[TB] FAIL rmf_tx_level got %0d want 0", tx_level); else passed++;
        checks++; if ({busy, MISO, rx_valid} !== 3'b000) $display("[TB] FAIL rmf_busy_miso_rxv got %b want 000", {busy, MISO, rx_valid}); else passed++;
        checks++; if (rx_level !== 3'd0) $display("[TB] FAIL rmf_rx_level got %0d want 0", rx_level); else passed++;
        push_tx(8'hC3);
        frame_begin(1'b0, 1'b0, 1'b0);
        spi_word(8'h5A, got, exp);
        checks++; if (got !== exp) $display("[TB] FAIL rmf_miso got %h want %h", got, exp); else passed++;
        frame_end();
        while (rx_exp_q.size() > 0) begin
            exp = rx_exp_q.pop_front();
            pop_rx(d, ok);
            checks++; if (!ok || d !== exp) $display("[TB] FAIL rmf_rx_data got %h valid %b want %h", d, ok, exp); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_mode0_msb();
        test_mode3_lsb();
        test_burst();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
